// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready encoder that places a signed immediate into an RV32 I/S/B/J
// instruction word, flags out-of-range or misaligned immediates and counts delivered errors.
module imm_instr_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ImmSrc,
    input  logic [6:0]       Opcode,
    input  logic [4:0]       Rd,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    input  logic [2:0]       Funct3,
    input  logic [31:0]      Imm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Instruction,
    output logic             ImmError,
    input  logic             ErrClear,
    output logic [CNT_W-1:0] ErrCount
);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } imm_fmt_e;

    logic             adv1, adv2, accept;

    logic             s1_valid_q;
    imm_fmt_e         s1_fmt_q;
    logic [6:0]       s1_opcode_q;
    logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]       s1_funct3_q;
    logic [31:0]      s1_imm_q;

    logic             out_valid_q;
    logic [31:0]      instr_q, instr_d;
    logic             imm_err_q, imm_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             fits_12, fits_13, fits_21;

    // A stage may load whenever the stage after it is empty or draining this cycle.
    assign adv2    = !out_valid_q || OutReady;
    assign adv1    = !s1_valid_q || adv2;
    assign accept  = InValid && adv1;
    assign InReady = adv1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= InValid;
        end
    end

    // NOTE: payload registers are qualified by their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_fmt_q    <= imm_fmt_e'(ImmSrc);
            s1_opcode_q <= Opcode;
            s1_rd_q     <= Rd;
            s1_rs1_q    <= Rs1;
            s1_rs2_q    <= Rs2;
            s1_funct3_q <= Funct3;
            s1_imm_q    <= Imm;
        end
    end

    // The immediate fits in N signed bits when everything from bit N-1 upward is one sign copy.
    assign fits_12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign fits_13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
    assign fits_21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        instr_d   = 32'd0;
        imm_err_d = 1'b0;
        case (s1_fmt_q)
            FMT_I: begin
                instr_d   = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                imm_err_d = !fits_12;
            end
            FMT_S: begin
                instr_d   = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:0], s1_opcode_q};
                imm_err_d = !fits_12;
            end
            FMT_B: begin
                instr_d   = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                imm_err_d = !fits_13 || s1_imm_q[0];
            end
            FMT_J: begin
                instr_d   = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_opcode_q};
                imm_err_d = !fits_21 || s1_imm_q[0];
            end
            default: begin
                instr_d   = 32'd0;
                imm_err_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            imm_err_q   <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                instr_q   <= instr_d;
                imm_err_q <= imm_err_d;
            end
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ErrClear) begin
            err_cnt_d = '0;
        end else if (out_valid_q && OutReady && imm_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign OutValid    = out_valid_q;
    assign Instruction = instr_q;
    assign ImmError    = imm_err_q;
    assign ErrCount    = err_cnt_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed vector table, backpressure, reset and
// saturation sequences, then random traffic against an arithmetic reference model and scoreboard.
module tb_imm_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid, OutReady, ErrClear;
    logic [1:0]  ImmSrc;
    logic [6:0]  Opcode;
    logic [4:0]  Rd, Rs1, Rs2;
    logic [2:0]  Funct3;
    logic [31:0] Imm;
    logic        InReady, OutValid, ImmError;
    logic [31:0] Instruction;
    logic [7:0]  ErrCount;
    logic        InReady2, OutValid2, ImmError2;
    logic [31:0] Instruction2;
    logic [1:0]  ErrCount2;

    always #5 clk = ~clk;

    imm_instr_encoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .ImmSrc(ImmSrc),
        .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Imm(Imm),
        .OutValid(OutValid), .OutReady(OutReady), .Instruction(Instruction),
        .ImmError(ImmError), .ErrClear(ErrClear), .ErrCount(ErrCount)
    );

    // Narrow-counter copy sharing all stimulus, used to observe saturation.
    imm_instr_encoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady2), .ImmSrc(ImmSrc),
        .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Imm(Imm),
        .OutValid(OutValid2), .OutReady(OutReady), .Instruction(Instruction2),
        .ImmError(ImmError2), .ErrClear(ErrClear), .ErrCount(ErrCount2)
    );

    typedef struct {
        logic [1:0]  src;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          edge_no;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_cnt8 = 0;
    int          m_cnt2 = 0;
    int          stall_seen = 0;
    exp_t        exp_q[$];
    logic [31:0] pend_instr;
    logic        pend_err;
    logic        last_acc;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_err;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference: each field is cut out of the immediate with shifts/masks and moved to its slot.
    function automatic logic [31:0] ref_encode(input int fmt, input logic [31:0] op,
                                               input logic [31:0] rd, input logic [31:0] rs1,
                                               input logic [31:0] rs2, input logic [31:0] f3,
                                               input logic [31:0] u);
        logic [31:0] common;
        common = (rs1 << 15) | (f3 << 12) | op;
        case (fmt)
            0: return ((u & 32'hfff) << 20) | common | (rd << 7);
            1: return (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | common | ((u & 32'h1f) << 7);
            2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20)
                      | common | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7);
            default: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21)
                      | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hff) << 12)
                      | (rd << 7) | op;
        endcase
    endfunction

    // Reference: plain signed range and evenness tests.
    function automatic logic ref_err(input int fmt, input int s);
        case (fmt)
            0, 1: return (s < -2048) || (s > 2047);
            2:    return (s < -4096) || (s > 4095) || (s % 2 != 0);
            default: return (s < -(1 << 20)) || (s > (1 << 20) - 1) || (s % 2 != 0);
        endcase
    endfunction

    task automatic set_beat(input int fmt, input int op, input int rd, input int rs1,
                            input int rs2, input int f3, input int imm);
        ImmSrc = 2'(fmt); Opcode = 7'(op); Rd = 5'(rd); Rs1 = 5'(rs1); Rs2 = 5'(rs2);
        Funct3 = 3'(f3); Imm = 32'(imm);
        pend_instr = ref_encode(fmt, 32'(Opcode), 32'(Rd), 32'(Rs1), 32'(Rs2), 32'(Funct3), Imm);
        pend_err   = ref_err(fmt, imm);
    endtask

    function automatic logic exp_out_valid();
        return (exp_q.size() > 0) && (cyc >= exp_q[0].edge_no + 1);
    endfunction

    // One clock: check outputs mid-cycle, then advance the scoreboard and counter model.
    task automatic step();
        logic exp_ready, exp_ov, ohs;
        #1;
        exp_ready = (exp_q.size() < 2) || OutReady;
        exp_ov    = exp_out_valid();
        check("in_ready", 32'(InReady), 32'(exp_ready));
        check("out_valid", 32'(OutValid), 32'(exp_ov));
        check("err_count", 32'(ErrCount), 32'(m_cnt8));
        check("err_count_w2", 32'(ErrCount2), 32'(m_cnt2));
        if (hold_prev) begin
            check("hold_instr", Instruction, prev_instr);
            check("hold_err", 32'(ImmError), 32'(prev_err));
        end
        if (exp_ov) begin
            check("instr", Instruction, exp_q[0].instr);
            check("imm_err", 32'(ImmError), 32'(exp_q[0].err));
        end
        if (!exp_ready) stall_seen++;
        ohs      = exp_ov && OutReady;
        last_acc = InValid && exp_ready;
        if (ErrClear) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (ohs && exp_q[0].err) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (ohs) void'(exp_q.pop_front());
        if (last_acc) exp_q.push_back('{pend_instr, pend_err, cyc + 1});
        hold_prev  = exp_ov && !OutReady;
        prev_instr = Instruction;
        prev_err   = ImmError;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_until_accepted(input string name);
        int c;
        InValid = 1'b1;
        last_acc = 1'b0;
        for (c = 0; c < 50 && !last_acc; c++) step();
        if (!last_acc) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain();
        InValid = 1'b0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 7'h13, 5'd1, 5'd2, 5'd31, 3'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
        vecs[1] = '{2'b01, 7'h23, 5'd9, 5'd2, 5'd5,  3'd2, 32'd8,        32'h00512423, 1'b0};
        vecs[2] = '{2'b10, 7'h63, 5'd0, 5'd0, 5'd0,  3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
        vecs[3] = '{2'b11, 7'h6F, 5'd1, 5'd7, 5'd9,  3'd5, 32'h00000800, 32'h001000EF, 1'b0};
        vecs[4] = '{2'b00, 7'h13, 5'd0, 5'd0, 5'd0,  3'd0, 32'd2048,     32'h80000013, 1'b1};
        vecs[5] = '{2'b10, 7'h63, 5'd0, 5'd0, 5'd0,  3'd0, 32'd3,        32'h00000163, 1'b1};

        reset = 1'b1; InValid = 1'b0; OutReady = 1'b1; ErrClear = 1'b0;
        set_beat(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_imm_err", 32'(ImmError), 32'd0);
        check("rst_err_count", 32'(ErrCount), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, streamed back to back.
        for (int i = 0; i < 6; i++) begin
            ImmSrc = vecs[i].src; Opcode = vecs[i].op; Rd = vecs[i].rd; Rs1 = vecs[i].rs1;
            Rs2 = vecs[i].rs2; Funct3 = vecs[i].f3; Imm = vecs[i].imm;
            pend_instr = vecs[i].instr;
            pend_err   = vecs[i].err;
            push_until_accepted("table");
        end
        drain();
        check("count_after_table", 32'(ErrCount), 32'd2);

        // Third error (misaligned J) whose handshake coincides with ErrClear.
        ImmSrc = 2'b11; Opcode = 7'h6F; Rd = 5'd1; Rs1 = 5'd0; Rs2 = 5'd0; Funct3 = 3'd0;
        Imm = 32'h801; pend_instr = 32'h001000EF; pend_err = 1'b1;
        push_until_accepted("jmis");
        InValid = 1'b0;
        for (int c = 0; c < 10 && !exp_out_valid(); c++) step();
        ErrClear = 1'b1;
        step();
        ErrClear = 1'b0;
        step();
        check("clear_priority", 32'(ErrCount), 32'd0);

        // Five errors: the 2-bit counter must stop at 3.
        for (int i = 0; i < 5; i++) begin
            set_beat(i % 2 == 0 ? 0 : 2, 7'h13, i, i, i, 0, i % 2 == 0 ? -2049 : 5);
            push_until_accepted("sat");
        end
        drain();
        check("sat_w2", 32'(ErrCount2), 32'd3);
        check("sat_w8", 32'(ErrCount), 32'd5);

        // Backpressure: OutReady low for stream cycles 2..7.
        begin
            int sent = 0;
            stall_seen = 0;
            for (int c = 0; c < 40 && !(sent == 4 && exp_q.size() == 0); c++) begin
                OutReady = !(c >= 2 && c <= 7);
                if (sent < 4) begin
                    set_beat(sent, 7'h33 + sent, sent + 1, sent + 2, sent + 3, sent, 16 * sent - 20);
                    InValid = 1'b1;
                end else begin
                    InValid = 1'b0;
                end
                step();
                if (last_acc) sent++;
            end
            OutReady = 1'b1;
            check("bp_all_sent", 32'(sent), 32'd4);
            check("bp_all_drained", 32'(exp_q.size()), 32'd0);
            check("bp_stalled", 32'(stall_seen > 0), 32'd1);
        end

        // Reset while both stages are full and the counter is non-zero.
        set_beat(1, 7'h23, 0, 1, 2, 3, 5000);
        push_until_accepted("pre_rst_err");
        drain();
        OutReady = 1'b0;
        for (int c = 0; c < 10 && !(exp_q.size() == 2 && exp_out_valid()); c++) begin
            set_beat(0, 7'h13, c, c, c, 1, c);
            InValid = 1'b1;
            step();
        end
        check("rst_setup_full", 32'(exp_q.size()), 32'd2);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(OutValid), 32'd0);
        check("midrst_err_count", 32'(ErrCount), 32'd0);
        exp_q.delete();
        m_cnt8 = 0; m_cnt2 = 0; hold_prev = 1'b0;
        InValid = 1'b0; OutReady = 1'b1;
        @(posedge clk); cyc++; @(negedge clk);
        reset = 1'b0;
        set_beat(3, 7'h6F, 4, 0, 0, 0, -2);
        push_until_accepted("post_rst");
        drain();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            int fmt, imm, sel;
            fmt = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: imm = int'($urandom);
                1: imm = int'($urandom_range(0, 8191)) - 4096;
                2: imm = int'($urandom_range(0, 1 << 22)) - (1 << 21);
                default: begin
                    int edges[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096,
                                      -4097, (1 << 20) - 2, -(1 << 20)};
                    imm = edges[$urandom_range(0, 9)];
                end
            endcase
            set_beat(fmt, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 7)), imm);
            InValid  = ($urandom_range(0, 9) < 7);
            OutReady = ($urandom_range(0, 9) < 7);
            ErrClear = ($urandom_range(0, 99) < 3);
            step();
        end
        ErrClear = 1'b0;
        OutReady = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
